// File: rtl/seg_capture.sv
// Seven-segment readback decoder: samples the multiplexed active-low display bus,
// filters each digit slot for stability and rebuilds the four displayed hex codes.
module seg_capture #(
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digit,
  output logic [3:0]  dval,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        err,
  output logic [6:0]  err_seg
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic        cap_v;
  logic [3:0]  cap_an;
  logic [6:0]  cap_seg;
  logic        prev_v;
  logic [3:0]  prev_an;
  logic [6:0]  prev_seg;
  logic [3:0]  cnt;
  logic [3:0]  seen;

  logic        qual;
  logic        same;
  logic        commit;
  logic [3:0]  cnt_nxt;
  logic [1:0]  slot;
  logic [3:0]  slot_oh;
  logic [3:0]  code;
  logic        known;
  logic [15:0] digit_new;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    qual      = cap_v && $onehot(~cap_an);
    same      = prev_v && (cap_an == prev_an) && (cap_seg == prev_seg);
    slot_oh   = ~cap_an;
    slot      = 2'd0;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    code      = 4'h0;
    known     = 1'b1;
    digit_new = digit;

    unique case (cap_an)
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot = 2'd0;
    endcase

    // A run only advances on strobed samples; idle cycles leave it untouched.
    if (cap_v) begin
      if (!qual) begin
        cnt_nxt = 4'd0;
      end else if (same) begin
        if (cnt != STABLE_C) begin
          cnt_nxt = cnt + 4'd1;
          commit  = (cnt + 4'd1 == STABLE_C);
        end
      end else begin
        cnt_nxt = 4'd1;
      end
    end

    // Inverse of the hex-to-glyph map, including the letter glyphs used for A..E.
    case (cap_seg)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0000111: code = 4'hA;
      7'b0101111: code = 4'hB;
      7'b0010001: code = 4'hC;
      7'b1000111: code = 4'hD;
      7'b0000110: code = 4'hE;
      7'b1111111: code = 4'hF;
      default:    known = 1'b0;
    endcase

    digit_new[{slot, 2'b00} +: 4] = code;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v       <= 1'b0;
      cap_an      <= 4'hF;
      cap_seg     <= 7'h7F;
      prev_v      <= 1'b0;
      prev_an     <= 4'hF;
      prev_seg    <= 7'h7F;
      cnt         <= 4'd0;
      seen        <= 4'd0;
      digit       <= 16'h0000;
      dval        <= 4'd0;
      frame       <= 16'h0000;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_seg     <= 7'h7F;
    end else begin
      cap_v       <= sample_en;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (sample_en) begin
        cap_an  <= an;
        cap_seg <= seg;
      end

      if (cap_v) begin
        prev_v   <= qual;
        prev_an  <= cap_an;
        prev_seg <= cap_seg;
      end
      cnt <= cnt_nxt;

      if (commit) begin
        if (known) begin
          digit <= digit_new;
          dval  <= dval | slot_oh;
          // The commit that completes the mask also snapshots the frame and starts a new one.
          if ((seen | slot_oh) == 4'hF) begin
            frame       <= digit_new;
            frame_valid <= 1'b1;
            seen        <= 4'd0;
          end else begin
            seen <= seen | slot_oh;
          end
        end else begin
          err     <= 1'b1;
          err_seg <= cap_seg;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Randomised scoreboard bench for seg_capture: a run-length reference model predicts
// every visible commit event and a monitor compares each event the DUT produces.
module tb_seg_capture;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digit;
  logic [3:0]  dval;
  logic [15:0] frame;
  logic        frame_valid;
  logic        err;
  logic [6:0]  err_seg;

  seg_capture #(.STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg(seg), .an(an),
    .digit(digit), .dval(dval), .frame(frame), .frame_valid(frame_valid),
    .err(err), .err_seg(err_seg)
  );

  typedef struct {
    int          cyc;
    bit          err;
    logic [6:0]  err_seg;
    bit          fv;
    logic [15:0] frame;
    logic [15:0] digit;
    logic [3:0]  dval;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  rst_q  = 1'b0;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0000111, 7'b0101111,
                             7'b0010001, 7'b1000111, 7'b0000110, 7'b1111111};

  // Reference model state: the current run and the expected visible outputs.
  int          run_len = 0;
  bit          r_v     = 0;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic [15:0] m_digit = 16'h0;
  logic [3:0]  m_dval  = 4'h0;
  logic [3:0]  m_seen  = 4'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    run_len = 0;
    r_v     = 0;
    m_digit = 16'h0;
    m_dval  = 4'h0;
    m_seen  = 4'h0;
    q.delete();
  endtask

  // cap_cyc is the clock edge that captures this sample; any commit shows one edge later.
  task automatic model(bit en, logic [3:0] a, logic [6:0] s, int cap_cyc);
    int          code;
    int          slot;
    bit          fire;
    ev_t         e;
    logic [15:0] nd;
    logic [3:0]  ndv;
    if (!en) return;
    if ($countones(~a) != 1) begin
      run_len = 0;
      r_v     = 0;
      return;
    end
    fire = 0;
    if (r_v && a == r_an && s == r_seg) begin
      if (run_len < STABLE) begin
        run_len++;
        fire = (run_len == STABLE);
      end
    end else begin
      run_len = 1;
      r_v     = 1;
      r_an    = a;
      r_seg   = s;
    end
    if (!fire) return;
    slot = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
    code = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == s) code = i;
    e.cyc = cap_cyc + 1;
    e.err = 0;
    e.err_seg = 7'h0;
    e.fv = 0;
    e.frame = 16'h0;
    if (code < 0) begin
      e.err     = 1;
      e.err_seg = s;
      e.digit   = m_digit;
      e.dval    = m_dval;
      q.push_back(e);
      return;
    end
    nd = m_digit;
    nd[slot*4 +: 4] = 4'(code);
    ndv = m_dval;
    ndv[slot] = 1'b1;
    m_seen[slot] = 1'b1;
    if (m_seen == 4'hF) begin
      e.fv    = 1;
      e.frame = nd;
      m_seen  = 4'h0;
    end
    e.digit = nd;
    e.dval  = ndv;
    if (e.fv || nd != m_digit || ndv != m_dval) q.push_back(e);
    m_digit = nd;
    m_dval  = ndv;
  endtask

  // Drives one cycle's inputs just after a rising edge.
  task automatic sample(bit en, logic [3:0] a, logic [6:0] s);
    sample_en = en;
    an        = a;
    seg       = s;
    model(en, a, s, cyc + 1);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(logic [3:0] a, logic [6:0] s, int n);
    for (int i = 0; i < n; i++) sample(1'b1, a, s);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) sample(1'b0, 4'hF, 7'h7F);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sample_en = 1'b0;
    @(posedge clk);
    model_reset();
    #4;
    check("rst_digit", 32'(digit), 32'h0);
    check("rst_dval", 32'(dval), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_seg", 32'(err_seg), 32'h7F);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: every visible output event must match the head of the scoreboard queue.
  initial begin
    ev_t         e;
    logic [15:0] last_digit;
    logic [3:0]  last_dval;
    last_digit = 16'h0;
    last_dval  = 4'h0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        last_digit = digit;
        last_dval  = dval;
      end else if (err || frame_valid || digit != last_digit || dval != last_dval) begin
        if (q.size() == 0) begin
          check("unexpected_event", {15'h0, err, frame_valid, 15'h0}, 32'h0);
        end else begin
          e = q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("err", 32'(err), 32'(e.err));
          if (e.err) check("err_seg", 32'(err_seg), 32'(e.err_seg));
          check("frame_valid", 32'(frame_valid), 32'(e.fv));
          if (e.fv) check("frame", 32'(frame), 32'(e.frame));
          check("digit", 32'(digit), 32'(e.digit));
          check("dval", 32'(dval), 32'(e.dval));
        end
        last_digit = digit;
        last_dval  = dval;
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check("missing_event_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sample_en = 1'b0;
    an = 4'hF;
    seg = 7'h7F;
    @(posedge clk);
    #2;
    do_reset();

    // Held digit commits once, STABLE+1 edges after it first appears.
    hold(4'b1110, 7'b0100100, 8);
    check("held_digit0", 32'(digit[3:0]), 32'h2);
    check("held_dval", 32'(dval), 32'h1);
    idle(2);

    // Full scan completes a frame.
    hold(4'b1110, 7'b0000111, 6);
    hold(4'b1101, 7'b0101111, 6);
    hold(4'b1011, 7'b0010001, 6);
    hold(4'b0111, 7'b1000111, 6);
    idle(2);
    check("scan_frame", 32'(frame), 32'hDCBA);

    // Pattern change before STABLE reloads the run.
    hold(4'b1110, 7'b0110000, 3);
    hold(4'b1110, 7'b1111001, 4);
    idle(2);
    check("toggle_digit0", 32'(digit[3:0]), 32'h1);

    // Unrecognised pattern raises err only.
    hold(4'b1101, 7'b1010101, 4);
    idle(2);
    check("bad_digit1", 32'(digit[7:4]), 32'hB);

    // Invalid anode patterns break runs; strobe gaps do not.
    hold(4'b1011, 7'b0010010, 3);
    sample(1'b1, 4'b1100, 7'b0010010);
    hold(4'b1011, 7'b0010010, 3);
    sample(1'b1, 4'b1111, 7'b0010010);
    for (int i = 0; i < 5; i++) begin
      sample(1'b1, 4'b1011, 7'b0010010);
      sample(1'b0, 4'b1011, 7'b0010010);
    end
    idle(2);
    check("gap_digit2", 32'(digit[11:8]), 32'h5);
    // Same segments on a new slot is a new run.
    hold(4'b0111, 7'b0010010, 4);
    idle(2);

    // Reset on the edge of a frame-completing commit discards it.
    do_reset();
    hold(4'b1110, 7'b0000000, 4);
    hold(4'b1101, 7'b0000000, 4);
    hold(4'b1011, 7'b0000000, 5);
    hold(4'b0111, 7'b0000110, 4);
    do_reset();

    // Randomised runs.
    for (int r = 0; r < 350; r++) begin
      logic [3:0] a;
      logic [6:0] s;
      int         len;
      a = ~(4'b0001 << $urandom_range(0, 3));
      s = ($urandom_range(0, 9) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 24) == 0)
          sample(1'b1, ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'b0110, s);
        else
          sample(($urandom_range(0, 3) != 0), a, s);
      end
    end

    idle(4);
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment readback decoder for the keypad/display path. It samples the multiplexed, active-low segment and anode bus that drives the display and applies a stability filter to each digit slot. Each stable pattern is decoded back into its 4-bit hex code, the inverse of the hex-to-segment glyph map. It reconstructs the four displayed digits as a frame for self-check logic, game-state readback and bench scoreboarding.

## Interface
- STABLE, default 4: consecutive identical qualifying samples required to commit a digit; legal range 2..15.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  sample strobe; the bus is sampled only on cycles where it is high.
- seg  in  7  segment lines, active low, bit order GFEDCBA (seg[6]=G, seg[0]=A).
- an  in  4  digit anodes, active low; an[i]=0 selects digit i.
- digit  out  16  committed codes; digit[4i+3:4i] holds slot i.
- dval  out  4  per-slot flag: the slot has committed at least once since reset.
- frame  out  16  snapshot of all four codes taken at frame completion.
- frame_valid  out  1  one-cycle pulse when frame updates.
- err  out  1  one-cycle pulse on commit of an unrecognised pattern.
- err_seg  out  7  last unrecognised pattern.

## Operation
- Decode map (seg → code): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0000111→A (t), 0101111→B (r), 0010001→C (y), 1000111→D (L), 0000110→E (E), 1111111→F (blank). Any other pattern is unrecognised.
- Qualifying sample: sample_en=1 and `an` has exactly one bit low. Zero or more than one low bit is a non-qualifying sample. It resets the run counter to 0 and clears the stored previous sample.
- Run counter, 4 bits: a qualifying sample equal to the previous qualifying sample (same `an` and `seg`) increments the counter, saturating at STABLE. A differing sample loads 1.
- Commit occurs on the sample where the counter reaches STABLE, exactly once per run. Saturation means there is no re-commit until the run breaks.
  - Recognised pattern: digit[slot] ← code, dval[slot] ← 1, seen[slot] ← 1.
  - Unrecognised pattern: err pulses, err_seg ← seg. digit, dval and seen are unchanged.
- Frame tracking: internal 4-bit seen mask. When a commit makes seen = 1111:
  - frame ← digit with the new code included.
  - frame_valid pulses.
  - seen clears to 0000 on the same edge.
- When sample_en=0 the run state holds. Gaps between strobes do not break a run.

## Timing
- seg/an are captured into registers on the clk edge where sample_en=1. The counter update and commit decision use the registered values.
- Latency: with the input constant and sample_en high from edge 1, the STABLE-th sample lands at edge STABLE. digit, dval and err update at edge STABLE+1, so outputs are visible STABLE+1 cycles after the input first appears.
- frame_valid is coincident with the commit that completes the mask, on the same edge as the digit update. It is high for exactly 1 cycle.
- Reset values: digit=0x0000, dval=0000, frame=0x0000, frame_valid=0, err=0, err_seg=1111111, counter=0, seen=0000.
- Reset asserted mid-run takes priority over everything. The counter clears and a commit due on that edge is discarded.
- Slot change with identical `seg` counts as a differing sample (counter ← 1).
- A slot committing twice before the others only overwrites digit[slot]. frame uses the latest value.

## Test plan
- Reset then hold an=1110, seg=0100100, sample_en=1 → digit[3:0]=2 and dval=0001 at cycle STABLE+1 (5). There is no earlier update and no second commit while held.
- Scan 1110/1101/1011/0111 with patterns 0000111, 0101111, 0010001, 1000111, each held 6 cycles → exactly one frame_valid pulse, frame=0xDCBA, then seen=0.
- Hold an=1110 with seg=0110000 for 3 samples, then toggle to 1111001 → no commit (counter reloads 1). After 4 more samples digit[3:0]=1.
- Slot 1 with seg=1010101 stable for 4 samples → err pulses 1 cycle, err_seg=1010101, and dval[1] and digit are unchanged.
- an=1100 (two low) or an=1111 inserted mid-run → the run breaks and commit needs STABLE new samples. With sample_en toggling 1/0, commit occurs after 4 enabled samples (about 8 cycles).
- Assert rst on the cycle a commit is due → all outputs at reset values next cycle, and no frame_valid.
